regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 17 +
 rtl/regfile_sb_if.sv | 40 ++++
 rtl/regfile_sb_scoreboard.sv | 67 ++++++
 rtl/regfile_sb.sv | 63 ++++++
 tb/tb_regfile_sb.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared pipeline constants for the register file / scoreboard slice.
//   XLEN      : default register data width
//   NREG      : default number of architectural registers
//   AW        : register-address width
//   addr_t    : register-address type
//   ZERO_REG  : index of the hard-wired zero register
package regfile_sb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef logic [AW-1:0] addr_t;

  localparam addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode / write-back bus between the pipeline and the register file.
//   wb_we/wb_addr/wb_data        : write-back port (from WB stage)
//   rs1_addr/rs2_addr            : decode source addresses
//   rs1_data/rs2_data            : combinational source operands
//   iss_valid/iss_we/iss_rd      : issue request from decode
//   stall                        : issue blocked this cycle (combinational)
//   busy                         : registered pending-write bits
// master = pipeline side, slave = register file side.
interface regfile_sb_if #(
  parameter int unsigned XLEN = regfile_sb_pkg::XLEN,
  parameter int unsigned NREG = regfile_sb_pkg::NREG
);
  import regfile_sb_pkg::addr_t;

  logic            wb_we;
  addr_t           wb_addr;
  logic [XLEN-1:0] wb_data;
  addr_t           rs1_addr;
  addr_t           rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            iss_valid;
  logic            iss_we;
  addr_t           iss_rd;
  logic            stall;
  logic [NREG-1:0] busy;

  modport master (
    output wb_we, wb_addr, wb_data, rs1_addr, rs2_addr,
           iss_valid, iss_we, iss_rd,
    input  rs1_data, rs2_data, stall, busy
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, rs1_addr, rs2_addr,
           iss_valid, iss_we, iss_rd,
    output rs1_data, rs2_data, stall, busy
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: tracks registers with an in-flight write and
// blocks issue until every source and the destination are ready.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   wb_we_i, wb_addr_i      : write-back (clears busy, bypasses readiness)
//   rs1_addr_i, rs2_addr_i  : sources of the issuing instruction
//   iss_valid_i, iss_we_i,
//   iss_rd_i                : issue request
//   stall_o                 : issue blocked (combinational)
//   busy_o                  : registered pending-write bits, bit 0 always 0
module scoreboard
  import regfile_sb_pkg::addr_t, regfile_sb_pkg::ZERO_REG;
#(
  parameter int unsigned NREG = regfile_sb_pkg::NREG
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_we_i,
  input  addr_t           wb_addr_i,
  input  addr_t           rs1_addr_i,
  input  addr_t           rs2_addr_i,
  input  logic            iss_valid_i,
  input  logic            iss_we_i,
  input  addr_t           iss_rd_i,
  output logic            stall_o,
  output logic [NREG-1:0] busy_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            rs1_rdy, rs2_rdy, rd_rdy;
  logic            accept;

  function automatic logic is_busy(input logic [NREG-1:0] vec, input addr_t a);
    is_busy = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (a == addr_t'(i)) is_busy = vec[i];
    end
  endfunction

  // A register being written back this cycle counts as ready: its value is
  // bypassed to the readers and the destination slot frees at this edge.
  always_comb begin
    rs1_rdy = !is_busy(busy_q, rs1_addr_i) || (wb_we_i && wb_addr_i == rs1_addr_i);
    rs2_rdy = !is_busy(busy_q, rs2_addr_i) || (wb_we_i && wb_addr_i == rs2_addr_i);
    rd_rdy  = !is_busy(busy_q, iss_rd_i)   || (wb_we_i && wb_addr_i == iss_rd_i);
    stall_o = iss_valid_i &&
              (!rs1_rdy || !rs2_rdy || (iss_we_i && iss_rd_i != ZERO_REG && !rd_rdy));
    accept  = iss_valid_i && !stall_o;
  end

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wb_we_i && wb_addr_i == addr_t'(i)) busy_d[i] = 1'b0;
      if (accept && iss_we_i && iss_rd_i == addr_t'(i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and issue scoreboard.
//   clk  : sole clock, rising-edge
//   rst  : synchronous active-high reset (clears registers and busy bits)
//   bus  : regfile_sb_if.slave -- write-back port, two combinational read
//          ports, issue request, stall and busy outputs
// x0 reads as zero and ignores writes.
module regfile_sb
  import regfile_sb_pkg::addr_t, regfile_sb_pkg::ZERO_REG;
#(
  parameter int unsigned XLEN = regfile_sb_pkg::XLEN,
  parameter int unsigned NREG = regfile_sb_pkg::NREG
) (
  input  logic clk,
  input  logic rst,
  regfile_sb_if.slave bus
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            wb_en;

  assign wb_en = bus.wb_we && (bus.wb_addr != ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (bus.wb_addr == addr_t'(i)) regs_q[i] <= bus.wb_data;
      end
    end
  end

  // Entry 0 is never selected, so x0 falls through to the zero default.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (bus.rs1_addr == addr_t'(i)) rs1_val = regs_q[i];
      if (bus.rs2_addr == addr_t'(i)) rs2_val = regs_q[i];
    end
    if (wb_en && bus.wb_addr == bus.rs1_addr) rs1_val = bus.wb_data;
    if (wb_en && bus.wb_addr == bus.rs2_addr) rs2_val = bus.wb_data;
  end

  assign bus.rs1_data = rs1_val;
  assign bus.rs2_data = rs2_val;

  scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_we_i     (bus.wb_we),
    .wb_addr_i   (bus.wb_addr),
    .rs1_addr_i  (bus.rs1_addr),
    .rs2_addr_i  (bus.rs2_addr),
    .iss_valid_i (bus.iss_valid),
    .iss_we_i    (bus.iss_we),
    .iss_rd_i    (bus.iss_rd),
    .stall_o     (bus.stall),
    .busy_o      (bus.busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: table of per-cycle vectors plus
// hand-written fill/readback and stall-hold sequences.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        wb_we;
    addr_t       wb_addr;
    logic [31:0] wb_data;
    addr_t       rs1;
    addr_t       rs2;
    logic        iss_valid;
    logic        iss_we;
    addr_t       iss_rd;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_stall;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic [31:0] busy;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic we, input int wa,
                              input logic [31:0] wd, input int a1, input int a2,
                              input logic iv, input logic iw, input int ird,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic es, input logic [31:0] eb);
    vec_t v;
    v.rst = r;  v.wb_we = we;  v.wb_addr = addr_t'(wa);  v.wb_data = wd;
    v.rs1 = addr_t'(a1);  v.rs2 = addr_t'(a2);
    v.iss_valid = iv;  v.iss_we = iw;  v.iss_rd = addr_t'(ird);
    v.e_rs1 = e1;  v.e_rs2 = e2;  v.e_stall = es;  v.e_busy = eb;
    return v;
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [31:0] k;
    k = 32'h9E37_79B9;
    return (k * i) ^ (32'(i) << 24) ^ 32'(i);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst           = v.rst;
    bus.wb_we     = v.wb_we;
    bus.wb_addr   = v.wb_addr;
    bus.wb_data   = v.wb_data;
    bus.rs1_addr  = v.rs1;
    bus.rs2_addr  = v.rs2;
    bus.iss_valid = v.iss_valid;
    bus.iss_we    = v.iss_we;
    bus.iss_rd    = v.iss_rd;
    expq.push_back('{rs1: v.e_rs1, rs2: v.e_rs2, stall: v.e_stall, busy: v.e_busy});
    #1;
    e = expq.pop_front();
    check32({tag, " rs1_data"}, bus.rs1_data, e.rs1);
    check32({tag, " rs2_data"}, bus.rs2_data, e.rs2);
    check32({tag, " stall"}, {31'b0, bus.stall}, {31'b0, e.stall});
    check32({tag, " busy"}, bus.busy, e.busy);
  endtask

  localparam logic [31:0] B3  = 32'h0000_0008;
  localparam logic [31:0] B7  = 32'h0000_0080;
  localparam logic [31:0] B9  = 32'h0000_0200;
  localparam logic [31:0] B20 = 32'h0010_0000;
  localparam logic [31:0] B21 = 32'h0020_0000;

  vec_t vecs[23];

  initial begin
    //           rst we wa wdata          r1 r2 iv iw ird  e_rs1          e_rs2          st busy
    vecs[0]  = mk(0, 0, 0, 32'h0,          5, 0, 0, 0, 0,  32'h0,         32'h0,         0, 32'h0);
    vecs[1]  = mk(0, 1, 5, 32'hAAAAAAAA,   5, 5, 0, 0, 0,  32'hAAAAAAAA,  32'hAAAAAAAA,  0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,          5, 0, 0, 0, 0,  32'hAAAAAAAA,  32'h0,         0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 32'h55555555,   0, 5, 0, 0, 0,  32'h0,         32'hAAAAAAAA,  0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,          0, 5, 0, 0, 0,  32'h0,         32'hAAAAAAAA,  0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0,          1, 2, 1, 1, 7,  32'h0,         32'h0,         0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0,          7, 0, 1, 0, 0,  32'h0,         32'h0,         1, B7);
    vecs[7]  = mk(0, 1, 7, 32'h55555555,   7, 0, 1, 0, 0,  32'h55555555,  32'h0,         0, B7);
    vecs[8]  = mk(0, 0, 0, 32'h0,          7, 0, 0, 0, 0,  32'h55555555,  32'h0,         0, 32'h0);
    vecs[9]  = mk(0, 0, 0, 32'h0,          0, 0, 1, 1, 3,  32'h0,         32'h0,         0, 32'h0);
    vecs[10] = mk(0, 1, 3, 32'h12345678,   3, 0, 1, 1, 3,  32'h12345678,  32'h0,         0, B3);
    vecs[11] = mk(0, 0, 0, 32'h0,          3, 0, 0, 0, 0,  32'h12345678,  32'h0,         0, B3);
    vecs[12] = mk(0, 0, 0, 32'h0,          0, 3, 1, 1, 9,  32'h0,         32'h12345678,  1, B3);
    vecs[13] = mk(0, 0, 0, 32'h0,          0, 0, 1, 1, 9,  32'h0,         32'h0,         0, B3);
    vecs[14] = mk(0, 0, 0, 32'h0,          0, 0, 1, 1, 3,  32'h0,         32'h0,         1, B3 | B9);
    vecs[15] = mk(1, 1,10, 32'hDEADBEEF,   9, 3, 1, 1, 11, 32'h0,         32'h12345678,  1, B3 | B9);
    vecs[16] = mk(0, 0, 0, 32'h0,          9, 3, 1, 1, 3,  32'h0,         32'h0,         0, 32'h0);
    vecs[17] = mk(0, 0, 0, 32'h0,         10, 5, 0, 0, 0,  32'h0,         32'h0,         0, B3);
    vecs[18] = mk(0, 1, 9, 32'hCAFEF00D,   9, 0, 0, 0, 0,  32'hCAFEF00D,  32'h0,         0, B3);
    vecs[19] = mk(0, 1, 3, 32'h0F0F0F0F,   9, 3, 0, 0, 0,  32'hCAFEF00D,  32'h0F0F0F0F,  0, B3);
    vecs[20] = mk(0, 0, 0, 32'h0,          9, 3, 0, 0, 0,  32'hCAFEF00D,  32'h0F0F0F0F,  0, 32'h0);
    vecs[21] = mk(0, 0, 0, 32'h0,          0, 0, 1, 1, 0,  32'h0,         32'h0,         0, 32'h0);
    vecs[22] = mk(0, 0, 0, 32'h0,          7, 9, 0, 0, 0,  32'h0,         32'hCAFEF00D,  0, 32'h0);

    rst           = 1'b1;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_we    = 1'b0;
    bus.iss_rd    = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 23; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Fill every register, then read them back in crossed pairs.
    for (int i = 1; i < 32; i++)
      apply(mk(0, 1, i, pat(i), i, 0, 0, 0, 0, pat(i), 32'h0, 0, 32'h0),
            $sformatf("fill%0d", i));
    for (int i = 1; i < 32; i++)
      apply(mk(0, 0, 0, 32'h0, i, 32 - i, 0, 0, 0, pat(i), pat(32 - i), 0, 32'h0),
            $sformatf("read%0d", i));

    // Stall held across several cycles until the producer writes back.
    apply(mk(0, 0, 0, 32'h0, 0, 0, 1, 1, 20, 32'h0, 32'h0, 0, 32'h0), "hold_iss");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 32'h0, 0, 20, 1, 1, 21, 32'h0, pat(20), 1, B20),
            $sformatf("hold_stall%0d", i));
    apply(mk(0, 1, 20, 32'h13579BDF, 0, 20, 1, 1, 21, 32'h0, 32'h13579BDF, 0, B20), "hold_wb");
    apply(mk(0, 0, 0, 32'h0, 21, 20, 0, 0, 0, pat(21), 32'h13579BDF, 0, B21), "hold_after");
    apply(mk(0, 1, 21, 32'h2468ACE0, 21, 0, 0, 0, 0, 32'h2468ACE0, 32'h0, 0, B21), "hold_wb2");
    apply(mk(0, 0, 0, 32'h0, 21, 20, 0, 0, 0, 32'h2468ACE0, 32'h13579BDF, 0, 32'h0), "hold_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
